// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-channel push-button synchroniser, debouncer and edge/long-press detector
module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_held
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW         = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] D_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] H_LAST  = CW'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit            HOLD_EN = (HOLD_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        logic [1:0]    sync_q, sync_d;
        state_t        state_q, state_d;
        logic [CW-1:0] dcnt_q, dcnt_d;
        logic [CW-1:0] hcnt_q, hcnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          held_q, held_d;
        logic [3:0]    out_q, out_d;
        logic          s;

        // sync_q[1] is the synchronised, normalised (pressed = 1) sample
        assign s = sync_q[1];

        always_comb begin
            sync_d    = {sync_q[0], key_raw[g] ^ ACTIVE_LOW};
            state_d   = state_q;
            dcnt_d    = dcnt_q;
            hcnt_d    = hcnt_q;
            level_d   = level_q;
            held_d    = held_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_WAIT;
                        dcnt_d  = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_d = IDLE;
                    end else if (dcnt_q == D_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end else begin
                        dcnt_d = sat_inc(dcnt_q);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state_d = RELEASE_WAIT;
                        dcnt_d  = '0;
                    end else if (HOLD_EN && (hcnt_q == H_LAST)) begin
                        held_d = 1'b1;
                    end else begin
                        hcnt_d = sat_inc(hcnt_q);
                    end
                end
                RELEASE_WAIT: begin
                    // a bounce back to pressed keeps hcnt so the hold time is not restarted
                    if (s) begin
                        state_d = PRESSED;
                    end else if (dcnt_q == D_LAST) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        held_d    = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        dcnt_d = sat_inc(dcnt_q);
                    end
                end
                default: state_d = IDLE;
            endcase
            out_d = {held_q, release_q, press_q, level_q};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q    <= 2'b00;
                state_q   <= IDLE;
                dcnt_q    <= '0;
                hcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                held_q    <= 1'b0;
                out_q     <= 4'b0000;
            end else begin
                sync_q    <= sync_d;
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                hcnt_q    <= hcnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                held_q    <= held_d;
                out_q     <= out_d;
            end
        end

        assign key_level[g]   = out_q[0];
        assign key_press[g]   = out_q[1];
        assign key_release[g] = out_q[2];
        assign key_held[g]    = out_q[3];
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed and randomised checks of key_conditioner against a run-length model
module tb_key_conditioner;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int H  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_raw;
    logic [NK-1:0] key_level, key_press, key_release, key_held;

    key_conditioner #(
        .NUM_KEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press),
        .key_release(key_release), .key_held(key_held)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int edge_n = 0;
    int t0, t1;

    // model: accepted level flips after D+1 consecutive disagreeing samples of the 2-edge-delayed key
    bit m_s1[NK], m_s2[NK], f_level[NK], f_press[NK], f_rel[NK], f_held[NK];
    int run[NK], hc[NK];
    logic [NK-1:0] e_level, e_press, e_rel, e_held;

    int press_cnt[NK], rel_cnt[NK], last_press[NK], last_rel[NK], held_rise[NK];
    logic [NK-1:0] prev_held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NK; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; f_level[c] = 0; f_press[c] = 0;
            f_rel[c] = 0; f_held[c] = 0; run[c] = 0; hc[c] = 0;
        end
        e_level = '0; e_press = '0; e_rel = '0; e_held = '0;
    endtask

    task automatic model_edge(input logic [NK-1:0] raw);
        for (int c = 0; c < NK; c++) begin
            bit s;
            e_level[c] = f_level[c]; e_press[c] = f_press[c];
            e_rel[c]   = f_rel[c];   e_held[c]  = f_held[c];
            f_press[c] = 0; f_rel[c] = 0;
            s = m_s2[c]; m_s2[c] = m_s1[c]; m_s1[c] = ~raw[c];
            if (s != f_level[c]) begin
                run[c]++;
                if (run[c] == D + 1) begin
                    f_level[c] = s;
                    run[c] = 0;
                    if (s) begin f_press[c] = 1; hc[c] = 0; end
                    else begin f_rel[c] = 1; f_held[c] = 0; end
                end
            end else begin
                if (f_level[c] && run[c] == 0) begin
                    if (hc[c] == H - 1) f_held[c] = 1;
                    else hc[c]++;
                end
                run[c] = 0;
            end
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < NK; c++) begin
            press_cnt[c] = 0; rel_cnt[c] = 0;
            last_press[c] = -1000; last_rel[c] = -1000; held_rise[c] = -1000;
        end
    endtask

    task automatic tick();
        logic [NK-1:0] r;
        @(posedge clk);
        r = key_raw;
        if (rst) model_reset();
        else model_edge(r);
        edge_n++;
        #1;
        check("level", 32'(key_level), 32'(e_level));
        check("press", 32'(key_press), 32'(e_press));
        check("release", 32'(key_release), 32'(e_rel));
        check("held", 32'(key_held), 32'(e_held));
        check("press_and_release", 32'(key_press & key_release), 0);
        for (int c = 0; c < NK; c++) begin
            if (key_press[c]) begin press_cnt[c]++; last_press[c] = edge_n; end
            if (key_release[c]) begin rel_cnt[c]++; last_rel[c] = edge_n; end
            if (key_held[c] && !prev_held[c]) held_rise[c] = edge_n;
        end
        prev_held = key_held;
    endtask

    initial begin
        int rate;
        rst = 1'b1;
        key_raw = 2'b11;
        prev_held = '0;
        model_reset();
        clear_counts();
        repeat (3) tick();
        check("reset_outputs", 32'({key_level, key_press, key_release, key_held}), 0);
        rst = 1'b0;
        repeat (3) tick();

        // clean press and release on channel 0
        key_raw[0] = 1'b0; t0 = edge_n + 1; clear_counts();
        repeat (12) tick();
        check("t1_press_latency", last_press[0] - t0, 7);
        check("t1_press_count", press_cnt[0], 1);
        check("t1_other_press", press_cnt[1], 0);
        check("t1_level", 32'(key_level), 1);
        key_raw[0] = 1'b1; t0 = edge_n + 1;
        repeat (12) tick();
        check("t1_release_latency", last_rel[0] - t0, 7);
        check("t1_release_count", rel_cnt[0], 1);

        // 3-cycle glitch must be rejected
        clear_counts();
        key_raw[0] = 1'b0;
        repeat (3) tick();
        key_raw[0] = 1'b1;
        repeat (12) tick();
        check("t2_glitch_press", press_cnt[0], 0);
        check("t2_glitch_level", 32'(key_level[0]), 0);

        // bounce on release
        key_raw[0] = 1'b0;
        repeat (12) tick();
        clear_counts();
        key_raw[0] = 1'b1; tick(); tick();
        key_raw[0] = 1'b0; tick();
        key_raw[0] = 1'b1; t0 = edge_n + 1;
        repeat (12) tick();
        check("t3_release_count", rel_cnt[0], 1);
        check("t3_release_latency", last_rel[0] - t0, 7);

        // long press on channel 1
        clear_counts();
        key_raw[1] = 1'b0; t0 = edge_n + 1;
        repeat (30) tick();
        key_raw[1] = 1'b1; t1 = edge_n + 1;
        repeat (12) tick();
        check("t4_press_latency", last_press[1] - t0, 7);
        check("t4_held_delay", held_rise[1] - last_press[1], 10);
        check("t4_release_latency", last_rel[1] - t1, 7);
        check("t4_held_cleared", 32'(key_held[1]), 0);

        // asynchronous reset while pressed
        key_raw[0] = 1'b0;
        repeat (10) tick();
        check("t5_level_before", 32'(key_level[0]), 1);
        clear_counts();
        #3 rst = 1'b1;
        #1;
        check("t5_async_zero", 32'({key_level, key_press, key_release, key_held}), 0);
        model_reset();
        tick(); tick();
        #2 rst = 1'b0;
        t0 = edge_n + 1;
        repeat (10) tick();
        check("t5_no_release", rel_cnt[0], 0);
        check("t5_repress_latency", last_press[0] - t0, 7);
        key_raw[0] = 1'b1;
        repeat (12) tick();

        // simultaneous press on both channels
        clear_counts();
        key_raw = 2'b00; t0 = edge_n + 1;
        repeat (12) tick();
        check("t6_press_same_edge", last_press[0], last_press[1]);
        check("t6_press_latency", last_press[0] - t0, 7);
        check("t6_press_count0", press_cnt[0], 1);
        check("t6_press_count1", press_cnt[1], 1);
        key_raw = 2'b11;
        repeat (12) tick();

        // randomised bursts with varying toggle rates and occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            rate = $urandom_range(1, 40);
            repeat (40) begin
                for (int c = 0; c < NK; c++)
                    if ($urandom_range(0, rate) == 0) key_raw[c] = ~key_raw[c];
                if ($urandom_range(0, 199) == 0) rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
Conditions the raw push-button inputs before they reach the game's Start, Roll and Choose stages. It replaces direct inversion of the low-active KEY bus with clean, debounced signals. Each channel synchronises its raw key into the clk domain, debounces it with a per-channel counter FSM, and produces:
- a debounced level,
- a one-cycle press pulse,
- a one-cycle release pulse,
- a long-press held flag.

The top level feeds key_level[0] to Roll/Start as roll_btn and key_press[1] to Choose as the confirm strobe.

Parameters:
NUM_KEYS, 2, number of independent key channels.
ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed (board KEY); 0 = raw reads 1 when pressed.
DEBOUNCE_CYCLES, 250000, stable cycles required to accept a change (5 ms at 50 MHz); legal range >= 1.
HOLD_CYCLES, 50000000, cycles in the pressed state before key_held asserts (1 s); 0 disables key_held.

Ports:
clk  input  1  system clock (MAX10_CLK1_50 domain); all logic on posedge.
rst  input  1  asynchronous, active-high reset.
key_raw  input  NUM_KEYS  raw, asynchronous button inputs.
key_level  output  NUM_KEYS  debounced pressed level, active-high.
key_press  output  NUM_KEYS  one-cycle pulse on accepted press.
key_release  output  NUM_KEYS  one-cycle pulse on accepted release.
key_held  output  NUM_KEYS  high while pressed for at least HOLD_CYCLES; cleared on release.

Behaviour:
Reset
- rst asserted: all synchroniser flops, counters and FSMs clear immediately, independent of clk.
- All outputs are 0 while rst is high; FSM state is IDLE.
- Synchroniser flops hold the normalised (pressed=1) value, so the reset value 0 means "released".

Synchroniser
- Per channel, the raw bit is normalised: inverted when ACTIVE_LOW=1.
- It then passes through a 2-flop synchroniser; the second flop output is s.
- s is the only signal used by the FSM.

Channels
- Each channel has an independent FSM, debounce counter dcnt and hold counter hcnt.
- Counters are unsigned, width clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1).
- Counters saturate and never wrap.

FSM states and transitions (evaluated each posedge):
- IDLE: if s=1, go to PRESS_WAIT with dcnt=0.
- PRESS_WAIT:
  - if s=0, return to IDLE (glitch rejected, no outputs);
  - else if dcnt = DEBOUNCE_CYCLES-1, go to PRESSED, set key_level=1, pulse key_press, set hcnt=0;
  - else increment dcnt.
- PRESSED:
  - if s=0, go to RELEASE_WAIT with dcnt=0;
  - else, if HOLD_CYCLES != 0 and hcnt = HOLD_CYCLES-1, set key_held=1 and hold it; otherwise increment hcnt (saturating).
- RELEASE_WAIT:
  - if s=1, return to PRESSED (bounce rejected; hcnt and key_held keep their values and hcnt resumes);
  - else if dcnt = DEBOUNCE_CYCLES-1, go to IDLE, set key_level=0, key_held=0, pulse key_release;
  - else increment dcnt.

Output and timing rules
- All outputs are registered; no combinational path from key_raw to any output.
- key_press and key_release are high for exactly one cycle per accepted transition; they are never high together on one channel.
- Latency for a steady press: if key_raw first reads pressed at posedge 0 and stays pressed, key_press is high during the cycle after posedge DEBOUNCE_CYCLES+3.
- key_level rises on the same posedge as key_press.
- Release latency is identical: key_release and the key_level fall occur DEBOUNCE_CYCLES+3 posedges after the raw release.
- key_held asserts HOLD_CYCLES posedges after key_press, provided the key stays in PRESSED/RELEASE_WAIT.

Boundary conditions
- DEBOUNCE_CYCLES=1: any s=1 sample is accepted on the next edge; latency is 4 edges.
- A pulse shorter than 2 cycles may be filtered by the synchroniser; a pulse shorter than DEBOUNCE_CYCLES after the synchroniser never produces key_press.
- Simultaneous activity on several channels is fully independent; there is no priority or interaction.
- Reset mid-press: outputs drop at once. If the key is still held after rst deasserts, a fresh full debounce runs and produces a new key_press.
- Reset never produces a key_release pulse.

Test Plan:
Bench configuration for all scenarios: NUM_KEYS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
1. Clean press: key_raw[0] driven 0 at edge 0 and held -> key_press[0]=1 only in the cycle after edge 7; key_level[0]=1 from edge 7; key_press[1], key_level[1] stay 0.
2. Glitch rejection: key_raw[0] low for 3 cycles then high -> no key_press, key_level stays 0, FSM ends in IDLE.
3. Bounce on release: while pressed, raw toggles high 2 cycles / low 1 / high steady -> key_level stays 1 through the bounce; exactly one key_release, 7 edges after the final steady-high edge.
4. Long press: hold key_raw[1] low for 30 cycles -> key_held[1] rises 10 edges after key_press[1] and clears together with key_release[1] after the raw release.
5. Async reset mid-press: assert rst between clk edges while key_level[0]=1 and key_raw[0] stays low -> all outputs 0 immediately with no key_release; after deassert, key_press[0] recurs 7 edges later.
6. Both channels pressed on the same edge -> key_press[0] and key_press[1] assert on the same cycle, each exactly once.
